// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: FSM states, default
// sizing and the helper that turns a word count into an index width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int LATENCY_DEFAULT = 2;

  // Index width needed to address DEPTH words; never narrower than one bit.
  function automatic int wordIdxWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int WORD_IDX_W = wordIdxWidth(DEPTH_DEFAULT);

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port and one combinational read port.
// Contents are deliberately left uninitialised.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IDX_W = WORD_IDX_W
) (
  input  logic             clk_i,
  input  logic             wrEn_i,
  input  logic [IDX_W-1:0] wrIdx_i,
  input  logic [31:0]      wrData_i,
  input  logic [IDX_W-1:0] rdIdx_i,
  output logic [31:0]      rdData_o
);

  logic [31:0] r_mem [DEPTH];

  // Commit a store on the rising edge when the write port is enabled.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      r_mem[wrIdx_i] <= wrData_i;
    end
  end

  assign rdData_o = r_mem[rdIdx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: accepts one load/store at a time, commits stores
// immediately, and answers after a fixed number of cycles with load data or
// an error flag. Storage lives in mem_word_array.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reqValid_i,
  input  logic        readEnable_i,
  input  logic        writeEnable_i,
  input  logic [31:0] address_i,
  input  logic [31:0] dataWrite_i,
  output logic        reqReady_o,
  output logic        respValid_o,
  output logic [31:0] dataRead_o,
  output logic        error_o,
  output logic        stall_o
);

  localparam int         IDX_W       = wordIdxWidth(DEPTH);
  localparam logic [2:0] BUSY_CYCLES = 3'(LATENCY - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [2:0]         r_cnt;
  logic [2:0]         w_nextCnt;
  logic               r_isLoad;
  logic               r_isErr;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_dataRead;

  logic               w_accept;
  logic               w_inRange;
  logic               w_reqErr;
  logic               w_loadOk;
  logic               w_storeOk;
  logic [IDX_W-1:0]   w_reqIdx;
  logic               w_enterResp;
  logic               w_respLoad;
  logic               w_respErr;
  logic [IDX_W-1:0]   w_rdIdx;
  logic [31:0]        w_rdData;
  logic               w_memWe;

  assign w_inRange = (address_i[31:2] < 30'(DEPTH));
  assign w_reqErr  = (address_i[1:0] != 2'b00) | ~w_inRange
                   | (readEnable_i & writeEnable_i);
  assign w_loadOk  = readEnable_i & ~w_reqErr;
  assign w_storeOk = writeEnable_i & ~w_reqErr;
  assign w_reqIdx  = address_i[IDX_W+1:2];

  // With single-cycle latency RESP is entered on the accepting edge, so the
  // response must be derived from the live request rather than the registers.
  assign w_respLoad = (r_state == IDLE) ? w_loadOk : r_isLoad;
  assign w_respErr  = (r_state == IDLE) ? w_reqErr : r_isErr;
  assign w_rdIdx    = (r_state == IDLE) ? w_reqIdx : r_idx;

  assign w_enterResp = (w_nextState == RESP);
  assign w_memWe     = w_accept & w_storeOk & ~rst_i;

  // Next-state, latency counter and handshake outputs.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    reqReady_o  = 1'b0;
    respValid_o = 1'b0;
    stall_o     = 1'b0;
    case (r_state)
      IDLE: begin
        reqReady_o = 1'b1;
        stall_o    = reqValid_i;
        if (reqValid_i) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_nextState = RESP;
          end else begin
            w_nextState = BUSY;
            w_nextCnt   = 3'd1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (r_cnt >= BUSY_CYCLES) begin
          w_nextState = RESP;
          w_nextCnt   = 3'd0;
        end else begin
          w_nextCnt = r_cnt + 3'd1;
        end
      end
      RESP: begin
        respValid_o = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 3'd0;
      end
    endcase
  end

  // State and counter register; reset abandons any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Capture the request on acceptance and the load result on entering RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_isLoad   <= 1'b0;
      r_isErr    <= 1'b0;
      r_idx      <= '0;
      r_dataRead <= 32'd0;
    end else begin
      if (w_accept) begin
        r_isLoad <= w_loadOk;
        r_isErr  <= w_reqErr;
        r_idx    <= w_reqIdx;
      end
      if (w_enterResp) begin
        if (w_respErr) begin
          r_dataRead <= 32'd0;
        end else if (w_respLoad) begin
          r_dataRead <= w_rdData;
        end
      end
    end
  end

  assign dataRead_o = r_dataRead;
  assign error_o    = (r_state == RESP) & r_isErr;

  mem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i    (clk_i),
    .wrEn_i   (w_memWe),
    .wrIdx_i  (w_reqIdx),
    .wrData_i (dataWrite_i),
    .rdIdx_i  (w_rdIdx),
    .rdData_o (w_rdData)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2 and one
// at LATENCY=1 share clock and reset. Expected responses are queued at issue
// time from a word-array reference model; a monitor compares on respValid_o.
module tb_data_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       reqValid, rdEn, wrEn;
  logic [1:0]       reqReady, respValid, errOut, stall;
  logic [1:0][31:0] addr, wdata, rdata;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][256];
  logic [31:0] lastRead [2];
  logic [31:0] heldData [2];
  int          lastAccept [2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle count, used to check response latency.
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u0 (
    .clk_i(clk), .rst_i(rst), .reqValid_i(reqValid[0]), .readEnable_i(rdEn[0]),
    .writeEnable_i(wrEn[0]), .address_i(addr[0]), .dataWrite_i(wdata[0]),
    .reqReady_o(reqReady[0]), .respValid_o(respValid[0]), .dataRead_o(rdata[0]),
    .error_o(errOut[0]), .stall_o(stall[0]));

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .reqValid_i(reqValid[1]), .readEnable_i(rdEn[1]),
    .writeEnable_i(wrEn[1]), .address_i(addr[1]), .dataWrite_i(wdata[1]),
    .reqReady_o(reqReady[1]), .respValid_o(respValid[1]), .dataRead_o(rdata[1]),
    .error_o(errOut[1]), .stall_o(stall[1]));

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic int qSize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: apply the request to the word array and queue the response.
  task automatic modelIssue(input int d, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    longint unsigned idx;
    idx   = longint'(a) >> 2;
    e.err = (a % 4 != 0) || (idx >= 256) || (rd && wr);
    if (e.err) begin
      e.data = 32'd0;
    end else if (wr) begin
      model[d][idx] = wd;
      e.data = lastRead[d];
    end else if (rd) begin
      e.data = model[d][idx];
    end else begin
      e.data = lastRead[d];
    end
    lastRead[d] = e.data;
    e.cyc = cyc + latOf(d) - 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Present one request, wait (bounded) for acceptance, then update the model.
  task automatic applyStimulus(input int d, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] wd);
    int waited = 0;
    @(negedge clk);
    reqValid[d] = 1'b1; rdEn[d] = rd; wrEn[d] = wr; addr[d] = a; wdata[d] = wd;
    while (!reqReady[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady[d]) begin
      checkOutput("accept timeout", 32'd0, 32'd1);
      reqValid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    modelIssue(d, rd, wr, a, wd);
    lastAccept[d] = cyc;
    reqValid[d] = 1'b0;
    rdEn[d] = 1'($urandom); wrEn[d] = 1'($urandom);
    addr[d] = $urandom; wdata[d] = $urandom;
  endtask

  // Wait (bounded) until a DUT has no outstanding response and is ready.
  task automatic waitIdle(input int d);
    int n = 0;
    @(negedge clk);
    while ((qSize(d) != 0 || !reqReady[d]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic flushModel();
    q0.delete(); q1.delete();
    for (int d = 0; d < 2; d++) begin
      lastRead[d] = 32'd0;
      heldData[d] = 32'd0;
    end
  endtask

  // Monitor: pop and compare on each response, otherwise check data is held.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        if (respValid[d]) begin
          exp_t e;
          if (qSize(d) == 0) begin
            checkOutput("unexpected response", 32'd1, 32'd0);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            checkOutput("response cycle", cyc, e.cyc);
            checkOutput("error flag", {31'd0, errOut[d]}, {31'd0, e.err});
            checkOutput("read data", rdata[d], e.data);
            heldData[d] = e.data;
          end
        end else begin
          checkOutput("held data", rdata[d], heldData[d]);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r;
    int op;
    int dsel;
    rst = 1'b1;
    reqValid = '0; rdEn = '0; wrEn = '0; addr = '0; wdata = '0;
    lastAccept[0] = 0; lastAccept[1] = 0;
    flushModel();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset ready", {31'd0, reqReady[d]}, 32'd1);
      checkOutput("reset respValid", {31'd0, respValid[d]}, 32'd0);
      checkOutput("reset error", {31'd0, errOut[d]}, 32'd0);
      checkOutput("reset data", rdata[d], 32'd0);
      checkOutput("reset stall", {31'd0, stall[d]}, 32'd0);
    end

    // Give words 0..15 and 255 known contents in both instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) applyStimulus(d, 1'b0, 1'b1, 32'(w * 4), $urandom);
      applyStimulus(d, 1'b0, 1'b1, 32'h3FC, $urandom);
      waitIdle(d);
    end

    // Store 0xDEADBEEF to 0x10 with cycle-by-cycle handshake checks.
    @(negedge clk);
    reqValid[0] = 1'b1; rdEn[0] = 1'b0; wrEn[0] = 1'b1;
    addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    #1;
    checkOutput("c0 ready", {31'd0, reqReady[0]}, 32'd1);
    checkOutput("c0 stall", {31'd0, stall[0]}, 32'd1);
    @(posedge clk);
    #1;
    modelIssue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    reqValid[0] = 1'b0;
    @(negedge clk);
    checkOutput("c1 ready", {31'd0, reqReady[0]}, 32'd0);
    checkOutput("c1 stall", {31'd0, stall[0]}, 32'd1);
    checkOutput("c1 respValid", {31'd0, respValid[0]}, 32'd0);
    @(negedge clk);
    checkOutput("c2 ready", {31'd0, reqReady[0]}, 32'd0);
    checkOutput("c2 stall", {31'd0, stall[0]}, 32'd0);
    checkOutput("c2 respValid", {31'd0, respValid[0]}, 32'd1);
    @(negedge clk);
    checkOutput("c3 ready", {31'd0, reqReady[0]}, 32'd1);
    checkOutput("c3 stall", {31'd0, stall[0]}, 32'd0);

    // Load 0x10 back and verify it is held across idle cycles.
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'd0);
    waitIdle(0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("load hold", rdata[0], 32'hDEADBEEF);
    end

    // Misaligned load, out-of-range store, then confirm boundary words intact.
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'd0);
    applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h3FC, 32'd0);

    // Both enables, then a no-op, then read back the untouched word.
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h0BADF00D);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h24, 32'h11111111);
    waitIdle(0);

    // Single-cycle latency: back-to-back stores respond every two cycles.
    for (int i = 0; i < 4; i++) begin
      int prev;
      prev = lastAccept[1];
      applyStimulus(1, 1'b0, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i));
      if (i > 0) checkOutput("L1 accept spacing", 32'(lastAccept[1] - prev), 32'd2);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 1'b0, 32'(i * 4), 32'd0);
    waitIdle(1);

    // Reset during BUSY abandons the response but keeps the committed store.
    applyStimulus(0, 1'b0, 1'b1, 32'h8, 32'h12345678);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    flushModel();
    @(negedge clk);
    checkOutput("post-reset respValid", {31'd0, respValid[0]}, 32'd0);
    checkOutput("post-reset ready", {31'd0, reqReady[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'd0);
    waitIdle(0);

    // Randomised mix of loads, stores, no-ops and illegal requests.
    for (int i = 0; i < 120; i++) begin
      dsel = int'($urandom % 2);
      r    = int'($urandom % 10);
      op   = int'($urandom % 10);
      if (r < 7)       a = 32'($urandom % 16) * 4;
      else if (r == 7) a = (32'($urandom % 16) * 4) | 32'(1 + $urandom % 3);
      else if (r == 8) a = ($urandom | 32'h400) & ~32'h3;
      else             a = 32'h3FC;
      case (op)
        0, 1, 2, 3, 9: applyStimulus(dsel, 1'b1, 1'b0, a, 32'd0);
        4, 5, 6:       applyStimulus(dsel, 1'b0, 1'b1, a, $urandom);
        7:             applyStimulus(dsel, 1'b0, 1'b0, a, $urandom);
        default:       applyStimulus(dsel, 1'b1, 1'b1, a, $urandom);
      endcase
    end
    waitIdle(0);
    waitIdle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..7.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port reqValid_i  input  1  memory-stage request present.
REQ-006 SHALL have port readEnable_i  input  1  request is a load.
REQ-007 SHALL have port writeEnable_i  input  1  request is a store.
REQ-008 SHALL have port address_i  input  32  byte address.
REQ-009 SHALL have port dataWrite_i  input  32  store data.
REQ-010 SHALL have port reqReady_o  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port respValid_o  output  1  one-cycle response strobe.
REQ-012 SHALL have port dataRead_o  output  32  load data, held until the next response.
REQ-013 SHALL have port error_o  output  1  response flags a rejected request; valid with respValid_o.
REQ-014 SHALL have port stall_o  output  1  pipeline freeze request.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 SHALL drive reqReady_o high only in IDLE.
REQ-017 SHALL accept a request on an edge where reqValid_i and reqReady_o are both high, registering opcode, address and data; inputs may change after acceptance.
REQ-018 SHALL transition IDLE->BUSY on accept when LATENCY>1, IDLE->RESP when LATENCY=1, BUSY->RESP after LATENCY-1 cycles in BUSY, and RESP->IDLE unconditionally.
REQ-019 SHALL assert respValid_o only in RESP, exactly LATENCY cycles after the accepting edge, for exactly one cycle.
REQ-020 SHALL drive stall_o = (state==BUSY) or (state==IDLE and reqValid_i); stall_o is low in RESP.
REQ-021 SHALL commit a store to word address[31:2] on the accepting edge.
REQ-022 SHALL capture load data on the edge entering RESP and hold dataRead_o thereafter until the next response.
REQ-023 SHALL reject with error_o=1, no storage write and dataRead_o=0 when address[1:0]!=0, address[31:2]>=DEPTH, or readEnable_i and writeEnable_i are both high.
REQ-024 SHALL treat an accepted request with neither enable high as a no-op that still responds, with error_o=0 and dataRead_o unchanged.
REQ-025 SHALL make a load issued after a store to the same address return the stored data (store commits before any later acceptance).
REQ-026 SHALL ignore reqValid_i in BUSY and RESP; a request in RESP is accepted no earlier than the following IDLE cycle.

Reset
REQ-027 SHALL, with rst_i high at an edge, enter IDLE and set respValid_o=0, error_o=0, dataRead_o=0, and clear the latency counter.
REQ-028 SHALL abandon any in-flight request on reset without responding; a store already committed at acceptance stays committed.
REQ-029 SHALL NOT initialise storage contents on reset.

Structure
REQ-030 SHALL take the FSM state enum, DEPTH default, LATENCY default and word-index width from shared package mem_pkg.
REQ-031 SHALL place storage in one sub-module mem_word_array (1 synchronous write port, 1 read port); FSM, counter and error checking stay in data_mem_responder.

Verification
REQ-032 Store 0xDEADBEEF to 0x10, LATENCY=2 -> reqReady_o low for 2 cycles, respValid_o at accept+2, error_o=0, stall_o high in cycle 0 and cycle 1 only.
REQ-033 Load 0x10 issued back-to-back after REQ-032 -> dataRead_o=0xDEADBEEF at accept+2, held through 3 idle cycles.
REQ-034 Load 0x13 and store 0x400 with DEPTH=256 -> error_o=1, dataRead_o=0, word 0 and word 255 unchanged.
REQ-035 Both enables high, address 0x20 -> error_o=1, no write; neither enable high -> response with error_o=0, dataRead_o unchanged.
REQ-036 LATENCY=1, 4 consecutive stores at 0x0/0x4/0x8/0xC -> one response every 2 cycles; loads read back all 4 values.
REQ-037 rst_i asserted during BUSY of a store of 0x12345678 to 0x8 -> no respValid_o, IDLE next cycle, later load of 0x8 returns 0x12345678.
